// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin arbiter that lets CHANNELS requesters share one
// memory port. A transaction moves through IDLE -> ACCESS -> DONE. The winning
// request is latched on grant, so a requester may change or drop its inputs
// once it has been granted. An access that sees no memory_ready for TIMEOUT
// cycles completes with response_error set.
//
// Handshake: a requester raises request_valid[i] and holds it, together with
// its request fields, until response_valid[i] pulses for one cycle. The memory
// side holds an access on the bus while memory_request is high, and completes
// it in any cycle where memory_ready is high.
module memory_arbiter #(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 16,
   parameter int CHANNELS      = 2,
   parameter int TIMEOUT       = 16
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [CHANNELS-1:0]               request_valid,
   input  logic [CHANNELS-1:0]               request_write,
   input  logic [CHANNELS*ADDRESS_WIDTH-1:0] request_address,
   input  logic [CHANNELS*DATA_WIDTH-1:0]    request_write_data,
   output logic [CHANNELS-1:0]               response_valid,
   output logic                              response_error,
   output logic [DATA_WIDTH-1:0]             response_read_data,
   input  logic [DATA_WIDTH-1:0]             memory_read_data,
   input  logic                              memory_ready,
   output logic                              memory_request,
   output logic                              memory_write_enable,
   output logic [ADDRESS_WIDTH-1:0]          memory_address,
   output logic [DATA_WIDTH-1:0]             memory_write_data,
   output logic                              busy
);

   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);
   localparam logic [CW-1:0] LAST_CHANNEL = CW'(CHANNELS - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                    state;
   logic [CW-1:0]             pointer;
   logic [CW-1:0]             channel;
   logic [TW-1:0]             counter;

   logic                      any_request;
   logic [CW-1:0]             winner;
   logic [CW-1:0]             next_pointer;
   logic                      sel_write;
   logic [ADDRESS_WIDTH-1:0]  sel_address;
   logic [DATA_WIDTH-1:0]     sel_write_data;
   logic [CHANNELS-1:0]       channel_onehot;
   int                        idx;

   // Round-robin search: first set request bit at or above the pointer, wrapping to 0.
   always_comb begin
      any_request    = 1'b0;
      winner         = '0;
      sel_write      = 1'b0;
      sel_address    = '0;
      sel_write_data = '0;
      idx            = 0;
      for (int k = 0; k < CHANNELS; k++) begin
         idx = int'(pointer) + k;
         if (idx >= CHANNELS) idx = idx - CHANNELS;
         if (!any_request && request_valid[CW'(idx)]) begin
            any_request    = 1'b1;
            winner         = CW'(idx);
            sel_write      = request_write[CW'(idx)];
            sel_address    = request_address[idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            sel_write_data = request_write_data[idx*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign next_pointer   = (winner == LAST_CHANNEL) ? '0 : winner + 1'b1;
   assign channel_onehot = CHANNELS'(1) << channel;
   assign busy           = (state != IDLE);

   // Transaction FSM; every bus and response output is a register written here.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state               <= IDLE;
         pointer             <= '0;
         channel             <= '0;
         counter             <= '0;
         response_valid      <= '0;
         response_error      <= 1'b0;
         response_read_data  <= '0;
         memory_request      <= 1'b0;
         memory_write_enable <= 1'b0;
         memory_address      <= '0;
         memory_write_data   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_request) begin
                  state               <= ACCESS;
                  channel             <= winner;
                  pointer             <= next_pointer;
                  counter             <= '0;
                  memory_request      <= 1'b1;
                  memory_write_enable <= sel_write;
                  memory_address      <= sel_address;
                  memory_write_data   <= sel_write_data;
               end
            end
            ACCESS: begin
               // Ready is checked first so a completion in the last allowed cycle is not an error.
               if (memory_ready) begin
                  response_read_data  <= memory_write_enable ? '0 : memory_read_data;
                  response_error      <= 1'b0;
                  response_valid      <= channel_onehot;
                  memory_request      <= 1'b0;
                  memory_write_enable <= 1'b0;
                  state               <= DONE;
               end else if (counter == LAST_WAIT) begin
                  response_read_data  <= '0;
                  response_error      <= 1'b1;
                  response_valid      <= channel_onehot;
                  memory_request      <= 1'b0;
                  memory_write_enable <= 1'b0;
                  state               <= DONE;
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            DONE: begin
               response_valid <= '0;
               response_error <= 1'b0;
               state          <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed testbench for memory_arbiter with default parameters.
module tb_memory_arbiter;

   logic        clock;
   logic        reset;
   logic [1:0]  request_valid;
   logic [1:0]  request_write;
   logic [31:0] request_address;
   logic [31:0] request_write_data;
   logic [1:0]  response_valid;
   logic        response_error;
   logic [15:0] response_read_data;
   logic [15:0] memory_read_data;
   logic        memory_ready;
   logic        memory_request;
   logic        memory_write_enable;
   logic [15:0] memory_address;
   logic [15:0] memory_write_data;
   logic        busy;

   int checks = 0;
   int errors = 0;

   memory_arbiter dut (
      .clock              (clock),
      .reset              (reset),
      .request_valid      (request_valid),
      .request_write      (request_write),
      .request_address    (request_address),
      .request_write_data (request_write_data),
      .response_valid     (response_valid),
      .response_error     (response_error),
      .response_read_data (response_read_data),
      .memory_read_data   (memory_read_data),
      .memory_ready       (memory_ready),
      .memory_request     (memory_request),
      .memory_write_enable(memory_write_enable),
      .memory_address     (memory_address),
      .memory_write_data  (memory_write_data),
      .busy               (busy)
   );

   // clock / reset block
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one cycle; outputs are sampled and inputs driven 1 ns after the edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      reset              = 1'b1;
      request_valid      = 2'b00;
      request_write      = 2'b00;
      request_address    = '0;
      request_write_data = '0;
      memory_read_data   = '0;
      memory_ready       = 1'b0;
      step();
      step();

      // Reset state
      chk("rst_mreq",  32'(memory_request), 32'h0);
      chk("rst_rv",    32'(response_valid), 32'h0);
      chk("rst_err",   32'(response_error), 32'h0);
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_mwe",   32'(memory_write_enable), 32'h0);
      chk("rst_addr",  32'(memory_address), 32'h0);
      chk("rst_rdata", 32'(response_read_data), 32'h0);
      reset = 1'b0;

      // Minimum latency read on channel 0
      request_valid    = 2'b01;
      request_write    = 2'b00;
      request_address  = {16'h0000, 16'h0040};
      memory_ready     = 1'b1;
      memory_read_data = 16'hBEEF;
      step();
      chk("lat_c1_mreq", 32'(memory_request), 32'h1);
      chk("lat_c1_addr", 32'(memory_address), 32'h0040);
      chk("lat_c1_mwe",  32'(memory_write_enable), 32'h0);
      chk("lat_c1_busy", 32'(busy), 32'h1);
      chk("lat_c1_rv",   32'(response_valid), 32'h0);
      step();
      chk("lat_c2_rv",    32'(response_valid), 32'h1);
      chk("lat_c2_rdata", 32'(response_read_data), 32'hBEEF);
      chk("lat_c2_err",   32'(response_error), 32'h0);
      chk("lat_c2_mreq",  32'(memory_request), 32'h0);
      request_valid = 2'b00;
      step();
      chk("lat_c3_rv",   32'(response_valid), 32'h0);
      chk("lat_c3_busy", 32'(busy), 32'h0);

      // Fresh reset, then both channels request and hold: grants alternate 0,1,0,1
      reset = 1'b1;
      step();
      reset = 1'b0;
      request_valid   = 2'b11;
      request_write   = 2'b00;
      request_address = {16'h0200, 16'h0100};
      memory_ready    = 1'b1;
      for (int g = 0; g < 4; g++) begin
         step();
         chk("rr_addr", 32'(memory_address), (g % 2 == 0) ? 32'h0100 : 32'h0200);
         chk("rr_mreq", 32'(memory_request), 32'h1);
         step();
         chk("rr_rv", 32'(response_valid), (g % 2 == 0) ? 32'h1 : 32'h2);
         if (g == 3) request_valid = 2'b00;
         step();
         chk("rr_idle_mreq", 32'(memory_request), 32'h0);
         chk("rr_idle_busy", 32'(busy), 32'h0);
      end

      // Channel 1 write with three wait cycles: bus stable for four ACCESS cycles
      request_valid      = 2'b10;
      request_write      = 2'b10;
      request_address    = {16'h00FF, 16'h0000};
      request_write_data = {16'h1234, 16'h0000};
      memory_ready       = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         chk("wr_mwe",   32'(memory_write_enable), 32'h1);
         chk("wr_addr",  32'(memory_address), 32'h00FF);
         chk("wr_wdata", 32'(memory_write_data), 32'h1234);
         chk("wr_mreq",  32'(memory_request), 32'h1);
         if (i == 3) memory_ready = 1'b1;
         step();
      end
      chk("wr_rv",    32'(response_valid), 32'h2);
      chk("wr_rdata", 32'(response_read_data), 32'h0);
      chk("wr_err",   32'(response_error), 32'h0);
      chk("wr_done_mwe", 32'(memory_write_enable), 32'h0);
      request_valid = 2'b00;
      request_write = 2'b00;
      memory_ready  = 1'b0;
      step();

      // Ready in the 16th ACCESS cycle on channel 0: normal completion
      request_valid    = 2'b01;
      request_address  = {16'h0000, 16'h0ABC};
      memory_read_data = 16'hA5A5;
      step();
      for (int i = 1; i <= 16; i++) begin
         chk("late_mreq", 32'(memory_request), 32'h1);
         if (i == 16) memory_ready = 1'b1;
         step();
      end
      chk("late_rv",    32'(response_valid), 32'h1);
      chk("late_err",   32'(response_error), 32'h0);
      chk("late_rdata", 32'(response_read_data), 32'hA5A5);
      request_valid = 2'b00;
      memory_ready  = 1'b0;
      step();

      // Timeout on channel 1: exactly 16 ACCESS cycles then an error response
      request_valid   = 2'b10;
      request_address = {16'h0333, 16'h0000};
      step();
      for (int i = 1; i <= 16; i++) begin
         chk("to_mreq", 32'(memory_request), 32'h1);
         chk("to_rv",   32'(response_valid), 32'h0);
         step();
      end
      chk("to_done_rv",    32'(response_valid), 32'h2);
      chk("to_done_err",   32'(response_error), 32'h1);
      chk("to_done_rdata", 32'(response_read_data), 32'h0);
      chk("to_done_mreq",  32'(memory_request), 32'h0);
      request_valid = 2'b00;
      step();
      chk("to_idle_err", 32'(response_error), 32'h0);

      // Next request after a timeout is served normally
      request_valid    = 2'b01;
      request_address  = {16'h0000, 16'h0444};
      memory_ready     = 1'b1;
      memory_read_data = 16'h5A5A;
      step();
      chk("post_to_addr", 32'(memory_address), 32'h0444);
      step();
      chk("post_to_rv",    32'(response_valid), 32'h1);
      chk("post_to_err",   32'(response_error), 32'h0);
      chk("post_to_rdata", 32'(response_read_data), 32'h5A5A);
      request_valid = 2'b00;
      memory_ready  = 1'b0;
      step();

      // Reset in the 2nd ACCESS cycle of a channel 1 read (pointer is 1 here)
      request_valid   = 2'b10;
      request_address = {16'h0222, 16'h0111};
      step();
      step();
      chk("abort_pre_mreq", 32'(memory_request), 32'h1);
      chk("abort_pre_addr", 32'(memory_address), 32'h0222);
      reset = 1'b1;
      request_valid = 2'b11;
      #1;
      chk("abort_mreq", 32'(memory_request), 32'h0);
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_rv",   32'(response_valid), 32'h0);
      step();
      chk("abort_hold_rv", 32'(response_valid), 32'h0);
      reset = 1'b0;
      memory_ready = 1'b1;
      step();
      chk("post_rst_addr", 32'(memory_address), 32'h0111);
      chk("post_rst_mreq", 32'(memory_request), 32'h1);
      step();
      chk("post_rst_rv", 32'(response_valid), 32'h1);
      request_valid = 2'b00;
      memory_ready  = 1'b0;
      step();
      chk("final_busy", 32'(busy), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of the data bus and every write/read data port.
REQ-002 Parameter ADDRESS_WIDTH, default 16, width of the memory address.
REQ-003 Parameter CHANNELS, default 2, number of requesters; legal range 2..8.
REQ-004 Parameter TIMEOUT, default 16, maximum number of ACCESS cycles without memory_ready; legal minimum 2.
REQ-005 clock  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 request_valid  input  CHANNELS  bit i high = channel i requests an access.
REQ-008 request_write  input  CHANNELS  bit i high = channel i access is a write.
REQ-009 request_address  input  CHANNELS*ADDRESS_WIDTH  channel i address in slice [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
REQ-010 request_write_data  input  CHANNELS*DATA_WIDTH  channel i write data in slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 response_valid  output  CHANNELS  one-cycle completion pulse for channel i.
REQ-012 response_error  output  1  high with response_valid when the access timed out.
REQ-013 response_read_data  output  DATA_WIDTH  read data, valid while response_valid is nonzero.
REQ-014 memory_read_data  input  DATA_WIDTH  data from memory.
REQ-015 memory_ready  input  1  memory completes the presented access this cycle.
REQ-016 memory_request  output  1  an access is presented on the memory bus.
REQ-017 memory_write_enable  output  1  presented access is a write.
REQ-018 memory_address  output  ADDRESS_WIDTH  presented address.
REQ-019 memory_write_data  output  DATA_WIDTH  presented write data.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, ACCESS, DONE.
REQ-022 IDLE with any request_valid bit set: select winner, latch its channel index, write flag, address and write data; next state ACCESS. IDLE with no request: remain IDLE.
REQ-023 Winner: round-robin -- first set request_valid bit searching upward from priority pointer, wrapping CHANNELS-1 to 0.
REQ-024 On each grant the pointer SHALL become (winner+1) mod CHANNELS; it is unchanged otherwise.
REQ-025 ACCESS: memory_request=1; memory_address, memory_write_data, memory_write_enable driven from latched values and stable for the whole state; memory_write_enable=0 outside ACCESS.
REQ-026 ACCESS with memory_ready=1: capture memory_read_data (reads) or zero (writes) into response_read_data, clear error, next state DONE.
REQ-027 ACCESS counter SHALL reset to 0 on entry and increment each ACCESS cycle with memory_ready=0; when memory_ready=0 and counter equals TIMEOUT-1: response_read_data=0, error=1, next state DONE.
REQ-028 memory_ready and timeout in the same cycle: ready wins, no error.
REQ-029 DONE: response_valid bit of latched channel =1 for exactly that cycle, response_error = latched error; next state IDLE unconditionally.
REQ-030 Minimum latency: request in cycle 0, ACCESS cycle 1, ready in cycle 1, response_valid in cycle 2, IDLE cycle 3.
REQ-031 Requester SHALL hold request_valid and its request fields until its response_valid; request_valid still high in the IDLE cycle after DONE is a new request.
REQ-032 Changes to request inputs during ACCESS or DONE SHALL NOT affect the latched transaction; a dropped request_valid still completes.
REQ-033 memory_request, response_valid and response_error SHALL be registered outputs with no combinational path from any input.

Reset
REQ-034 reset high SHALL immediately force IDLE, pointer 0, counter 0, and all outputs 0, including mid-ACCESS; aborted transaction produces no response.
REQ-035 First edge after reset release SHALL evaluate requests as in IDLE with pointer 0.

Verification
REQ-036 Default params; channel 0 read of 0x0040, memory_ready in first ACCESS cycle with data 0xBEEF -> memory_request high cycle 1 only, response_valid=2'b01 cycle 2, response_read_data=0xBEEF, error 0.
REQ-037 Channels 0 and 1 request simultaneously after reset and hold -> grants 0, 1, 0, 1 in order; no memory_request in the IDLE cycles between them.
REQ-038 Channel 1 write 0x1234 to 0x00FF, memory_ready after 3 wait cycles -> memory_write_enable, address, data stable 4 cycles; response_valid=2'b10, read data 0.
REQ-039 memory_ready never asserted, TIMEOUT=16 -> exactly 16 ACCESS cycles, then response_valid with response_error=1, read data 0; next request served normally.
REQ-040 memory_ready asserted in the 16th ACCESS cycle -> normal completion, response_error=0.
REQ-041 reset asserted in 2nd ACCESS cycle -> memory_request, busy low immediately; no response_valid; pointer 0 after release.
